// File: rtl/v_issue_ctrl_pkg.sv
// Shared opcode constants, instruction field helpers and head-entry decode for the
// vector issue controller.
package v_issue_ctrl_pkg;

    localparam logic [6:0] VOPC_LOAD  = 7'b0000111;
    localparam logic [6:0] VOPC_STORE = 7'b0100111;
    localparam logic [6:0] VOPC_OPV   = 7'b1010111;
    localparam logic [2:0] F3_OPIVV   = 3'b000;

    // Register usage of one instruction as seen by the scoreboard
    typedef struct packed {
        logic       rd_a_en;
        logic [4:0] rd_a;
        logic       rd_b_en;
        logic [4:0] rd_b;
        logic       wr_en;
        logic [4:0] wr;
        logic       is_load;
    } vdec_t;

    function automatic logic [6:0] inst_opc(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [2:0] inst_f3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [4:0] inst_vd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_vs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_vs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Unknown opcodes decode to all-zero: no reads, no writes, never blocked
    function automatic vdec_t vdec(input logic [31:0] inst);
        vdec_t d;
        d = '0;
        case (inst_opc(inst))
            VOPC_LOAD: begin
                d.wr_en   = 1'b1;
                d.wr      = inst_vd(inst);
                d.is_load = 1'b1;
            end
            VOPC_STORE: begin
                // vs3 lives in the vd field
                d.rd_a_en = 1'b1;
                d.rd_a    = inst_vd(inst);
            end
            VOPC_OPV: begin
                d.wr_en   = 1'b1;
                d.wr      = inst_vd(inst);
                d.rd_a_en = 1'b1;
                d.rd_a    = inst_vs2(inst);
                // Only the vector-vector form uses vs1 as a vreg
                d.rd_b_en = (inst_f3(inst) == F3_OPIVV);
                d.rd_b    = inst_vs1(inst);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/v_issue_fifo.sv
// Synchronous instruction buffer with push/pop/flush and full/empty/count status.
module v_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy state; flush discards everything including a same-cycle push
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage array, no reset needed since reads are gated by the count
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/v_issue_ctrl.sv
// Vector issue controller: buffers instructions, blocks RAW/WAW hazards with a per-vreg
// countdown scoreboard and issues at most one instruction per cycle through a register.
module v_issue_ctrl
    import v_issue_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned NUM_VREG   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    input  logic [31:0] in_inst_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic [31:0] vinst_o,
    output logic        vinst_valid_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);
    localparam int unsigned MAX_LAT = max_u(LOAD_LAT, ALU_LAT);
    localparam int unsigned SB_W    = $clog2(MAX_LAT + 1);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);

    logic [31:0]     fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    vdec_t           dec;
    logic            blocked;
    logic            issue;
    logic            sb_load;
    logic [SB_W-1:0] sb_load_val;
    logic            sb_any;
    logic [SB_W-1:0] sb_q [NUM_VREG];

    logic [31:0]     vinst_q;
    logic            vinst_valid_q;
    logic [31:0]     stall_q;

    v_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid_i),
        .push_data (in_inst_i),
        .pop       (issue),
        .flush     (flush_i),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready_o = !fifo_full;

    // Hazard check on the head: a reader may go when the pending write lands this edge
    // (counter == 1, regfile bypasses); a writer must wait until the counter is zero
    always_comb begin
        dec     = vdec(fifo_head);
        blocked = 1'b0;
        if (dec.rd_a_en && (sb_q[dec.rd_a] > SB_ONE)) blocked = 1'b1;
        if (dec.rd_b_en && (sb_q[dec.rd_b] > SB_ONE)) blocked = 1'b1;
        if (dec.wr_en && (sb_q[dec.wr] != '0))        blocked = 1'b1;
    end

    assign issue       = !fifo_empty && !blocked;
    // An issue killed by flush must not reserve its destination
    assign sb_load     = issue && !flush_i && dec.wr_en;
    assign sb_load_val = dec.is_load ? SB_W'(LOAD_LAT) : SB_W'(ALU_LAT);

    // Reduce the scoreboard for the busy indication
    always_comb begin
        sb_any = 1'b0;
        for (int unsigned r = 0; r < NUM_VREG; r++) begin
            if (sb_q[r] != '0) sb_any = 1'b1;
        end
    end

    // Scoreboard countdown; a new issue reload wins over the decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_VREG; r++) sb_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_VREG; r++) begin
                if (sb_load && (32'(dec.wr) == r)) begin
                    sb_q[r] <= sb_load_val;
                end else if (sb_q[r] != '0) begin
                    sb_q[r] <= sb_q[r] - SB_W'(1);
                end
            end
        end
    end

    // Registered issue port; zero whenever nothing is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            vinst_q       <= '0;
            vinst_valid_q <= 1'b0;
        end else if (issue && !flush_i) begin
            vinst_q       <= fifo_head;
            vinst_valid_q <= 1'b1;
        end else begin
            vinst_q       <= '0;
            vinst_valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles a present head was held back by a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!fifo_empty && blocked && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign vinst_o       = vinst_q;
    assign vinst_valid_o = vinst_valid_q;
    assign stall_cnt_o   = stall_q;
    assign busy_o        = (fifo_count != '0) || vinst_valid_q || sb_any;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Bench for v_issue_ctrl: directed vector table, hand sequences for flush/reset/fill,
// then random traffic against a cycle-indexed reference model.
module tb_v_issue_ctrl;
    localparam int DEPTH    = 4;
    localparam int LOAD_LAT = 2;
    localparam int ALU_LAT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [31:0] in_inst_i;
    logic        in_ready_o;
    logic        flush_i;
    logic [31:0] vinst_o;
    logic        vinst_valid_o;
    logic        busy_o;
    logic [31:0] stall_cnt_o;

    v_issue_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .LOAD_LAT   (LOAD_LAT),
        .ALU_LAT    (ALU_LAT),
        .NUM_VREG   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_inst_i     (in_inst_i),
        .in_ready_o    (in_ready_o),
        .flush_i       (flush_i),
        .vinst_o       (vinst_o),
        .vinst_valid_o (vinst_valid_o),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a write issued at edge t with latency L lands at edge t+L.
    // land[r] holds that edge number; cyc counts edges since the model was started.
    int          cyc;
    int          land [32];
    logic [31:0] mq [$];
    logic [31:0] m_vinst;
    bit          m_valid;
    logic [31:0] m_stall;
    logic [31:0] seen [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] opv(input int vd, input int vs2, input int vs1,
                                        input logic [2:0] f3);
        return {6'b0, 1'b1, 5'(vs2), 5'(vs1), f3, 5'(vd), 7'b1010111};
    endfunction

    function automatic logic [31:0] vld(input int vd, input int tag);
        return {6'b0, 1'b1, 5'b0, 5'(tag), 3'b110, 5'(vd), 7'b0000111};
    endfunction

    function automatic logic [31:0] vse(input int vs3);
        return {6'b0, 1'b1, 5'b0, 5'b0, 3'b110, 5'(vs3), 7'b0100111};
    endfunction

    // Pending cycles until a register's write lands, as seen in the current cycle
    function automatic int pend(input logic [4:0] r);
        int p;
        p = land[int'(r)] - cyc;
        return (p > 0) ? p : 0;
    endfunction

    function automatic bit m_blocked(input logic [31:0] i);
        case (i[6:0])
            7'b0000111: return pend(i[11:7]) != 0;
            7'b0100111: return pend(i[11:7]) > 1;
            7'b1010111: begin
                if (pend(i[11:7]) != 0) return 1'b1;
                if (pend(i[24:20]) > 1) return 1'b1;
                if (i[14:12] == 3'b000 && pend(i[19:15]) > 1) return 1'b1;
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_lat(input logic [31:0] i);
        case (i[6:0])
            7'b0000111: return LOAD_LAT;
            7'b1010111: return ALU_LAT;
            default:    return 0;
        endcase
    endfunction

    task automatic m_reset();
        mq.delete();
        m_vinst = '0;
        m_valid = 1'b0;
        m_stall = '0;
        for (int r = 0; r < 32; r++) land[r] = 0;
    endtask

    // One clock: drive inputs, check pre-edge ready, advance model, check post-edge outputs
    task automatic step(input bit v, input logic [31:0] inst, input bit fl, input bit r,
                        output bit rdy);
        bit          m_ready;
        bit          iss;
        logic [31:0] h;
        in_valid_i = v;
        in_inst_i  = inst;
        flush_i    = fl;
        rst        = r;
        #1;
        m_ready = (mq.size() < DEPTH);
        rdy     = in_ready_o;
        chk("in_ready", {31'b0, in_ready_o}, {31'b0, m_ready});
        if (r) begin
            m_reset();
        end else begin
            iss = 1'b0;
            h   = '0;
            if (mq.size() != 0) begin
                h = mq[0];
                if (m_blocked(h)) begin
                    if (m_stall != 32'hFFFF_FFFF) m_stall++;
                end else begin
                    iss = 1'b1;
                end
            end
            if (fl) begin
                mq.delete();
                m_vinst = '0;
                m_valid = 1'b0;
            end else begin
                if (iss) begin
                    void'(mq.pop_front());
                    if (m_lat(h) != 0) land[int'(h[11:7])] = cyc + 1 + m_lat(h);
                end
                m_valid = iss;
                m_vinst = iss ? h : '0;
                if (v && m_ready) mq.push_back(inst);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("vinst_valid", {31'b0, vinst_valid_o}, {31'b0, m_valid});
        chk("vinst", vinst_o, m_vinst);
        chk("stall_cnt", stall_cnt_o, m_stall);
        begin
            bit b;
            b = (mq.size() != 0) || m_valid;
            for (int k = 0; k < 32; k++) if (land[k] > cyc) b = 1'b1;
            chk("busy", {31'b0, busy_o}, {31'b0, b});
        end
        if (vinst_valid_o) seen.push_back(vinst_o);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] inst;
        bit          ready;
        bit          valid;
        logic [31:0] out;
        logic [31:0] stall;
        bit          busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit          rdy;
        bit          saw_full;
        int          guard;
        logic [31:0] base;
        logic [31:0] a_i, b_i, l_i, x_i, s_i, y_i, w_i;

        rst        = 1'b1;
        in_valid_i = 1'b0;
        in_inst_i  = '0;
        flush_i    = 1'b0;
        cyc        = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {31'b0, vinst_valid_o}, 32'd0);
        chk("reset_vinst", vinst_o, 32'd0);
        chk("reset_stall", stall_cnt_o, 32'd0);
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_ready", {31'b0, in_ready_o}, 32'd1);
        rst = 1'b0;

        // Independent back-to-back OP-V, then load-use with a dependent store
        a_i = opv(1, 2, 3, 3'b000);
        b_i = opv(4, 5, 6, 3'b000);
        l_i = vld(1, 0);
        x_i = opv(2, 1, 3, 3'b000);
        s_i = vse(2);
        tbl[0] = '{1'b1, a_i, 1'b1, 1'b0, 32'h0, 32'd0, 1'b1};
        tbl[1] = '{1'b1, b_i, 1'b1, 1'b1, a_i,   32'd0, 1'b1};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, b_i, 32'd0, 1'b1};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0};
        tbl[4] = '{1'b1, l_i, 1'b1, 1'b0, 32'h0, 32'd0, 1'b1};
        tbl[5] = '{1'b1, x_i, 1'b1, 1'b1, l_i,   32'd0, 1'b1};
        tbl[6] = '{1'b1, s_i, 1'b1, 1'b0, 32'h0, 32'd1, 1'b1};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b1, x_i, 32'd1, 1'b1};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b1, s_i, 32'd1, 1'b1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].inst, 1'b0, 1'b0, rdy);
            chk($sformatf("tbl%0d_ready", i), {31'b0, rdy}, {31'b0, tbl[i].ready});
            chk($sformatf("tbl%0d_valid", i), {31'b0, vinst_valid_o}, {31'b0, tbl[i].valid});
            chk($sformatf("tbl%0d_vinst", i), vinst_o, tbl[i].out);
            chk($sformatf("tbl%0d_stall", i), stall_cnt_o, tbl[i].stall);
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy_o}, {31'b0, tbl[i].busy});
        end

        // WAW behind a load waits for the counter to reach zero: two stall cycles
        base = m_stall;
        step(1'b1, vld(7, 0), 1'b0, 1'b0, rdy);
        step(1'b1, opv(7, 8, 7, 3'b100), 1'b0, 1'b0, rdy);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        chk("waw_stall", stall_cnt_o, base + 32'd2);
        // OPIVX with vs1 field equal to the loaded register is not a reader
        base = m_stall;
        step(1'b1, vld(7, 1), 1'b0, 1'b0, rdy);
        step(1'b1, opv(9, 8, 7, 3'b100), 1'b0, 1'b0, rdy);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        chk("opivx_no_raw", stall_cnt_o, base);

        // Fill behind a WAW chain; 12 tagged loads must come out in order across wrap
        seen.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 12; i++) begin
            guard = 0;
            rdy   = 1'b0;
            while (!rdy && guard < 20) begin
                step(1'b1, vld(10, i), 1'b0, 1'b0, rdy);
                if (!rdy) saw_full = 1'b1;
                guard++;
            end
            if (!rdy) chk("push_timeout", 32'd0, 32'd1);
        end
        repeat (40) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        chk("saw_full", {31'b0, saw_full}, 32'd1);
        chk("order_count", seen.size(), 32'd12);
        for (int i = 0; i < 12 && i < seen.size(); i++) begin
            chk($sformatf("order%0d", i), seen[i], vld(10, i));
        end

        // Flush with three buffered entries, an issue pending and a load in flight
        w_i = vld(12, 1);
        step(1'b1, vld(12, 0), 1'b0, 1'b0, rdy);
        step(1'b1, w_i, 1'b0, 1'b0, rdy);
        step(1'b1, opv(20, 21, 22, 3'b000), 1'b0, 1'b0, rdy);
        step(1'b1, opv(23, 24, 25, 3'b000), 1'b0, 1'b0, rdy);
        step(1'b1, opv(26, 27, 28, 3'b000), 1'b0, 1'b0, rdy);
        chk("preflush_issue", vinst_o, w_i);
        step(1'b1, opv(29, 30, 31, 3'b000), 1'b1, 1'b0, rdy);
        chk("flush_valid", {31'b0, vinst_valid_o}, 32'd0);
        chk("flush_vinst", vinst_o, 32'd0);
        chk("flush_busy_inflight", {31'b0, busy_o}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        chk("flush_ready", {31'b0, rdy}, 32'd1);
        chk("flush_drained", {31'b0, busy_o}, 32'd0);

        // Reset mid-stream, then a reader of the abandoned load issues without stalling
        step(1'b1, vld(3, 0), 1'b0, 1'b0, rdy);
        step(1'b1, opv(4, 3, 3, 3'b000), 1'b0, 1'b0, rdy);
        step(1'b1, opv(6, 3, 3, 3'b000), 1'b0, 1'b1, rdy);
        chk("rst_valid", {31'b0, vinst_valid_o}, 32'd0);
        chk("rst_vinst", vinst_o, 32'd0);
        chk("rst_stall", stall_cnt_o, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        y_i = opv(5, 3, 3, 3'b000);
        step(1'b1, y_i, 1'b0, 1'b0, rdy);
        chk("rst_ready", {31'b0, rdy}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        chk("post_rst_issue", vinst_o, y_i);
        chk("post_rst_stall", stall_cnt_o, 32'd0);

        // Random traffic over a small register set to provoke hazards
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ri;
            int          kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       ri = vld($urandom_range(0, 3), $urandom_range(0, 31));
                1:       ri = vse($urandom_range(0, 3));
                2:       ri = opv($urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 3),
                                  ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b100);
                default: ri = {$urandom_range(0, 32'h1FF_FFFF), 7'b0110011};
            endcase
            step(($urandom_range(0, 9) < 7), ri, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 149) == 0), rdy);
        end
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
